// File: rtl/muxn_rr.sv
// -----------------------------------------------------------------------------
// muxn_rr -- N-to-1 streaming multiplexer with a registered output stage.
//
// Each cycle at most one input channel is granted. The granted channel's beat
// is captured into a single output register, which is drained by out_ready.
// The output register can drain and reload on the same edge, so the mux
// sustains one beat per cycle.
//
// Arbitration mode is chosen at build time by the macro MUXN_RR_ROUND_ROBIN_EN:
//   defined   : round-robin. The search starts at a priority pointer that moves
//               to (winner + 1) mod N after every transfer.
//   undefined : fixed priority. The lowest-numbered valid channel wins. The
//               pointer is a constant 0.
//
// Handshake: a beat moves from channel i when in_valid[i] & in_ready[i] are
// both high on a rising clk edge. The output beat leaves when
// out_valid & out_ready are both high on a rising edge. Valid never waits for
// ready. in_ready[i] is high only for the granted channel, and only when the
// output register is empty or is being drained in the same cycle.
//
// Parameters:
//   N  : number of input channels (2..16)
//   W  : data width per channel (1..64)
//   SW : width of the channel index (N <= 2**SW)
//
// Ports:
//   clk       : clock; all state updates on its rising edge
//   rst_n     : asynchronous active-low reset
//   in_data   : packed channel data; channel i is in_data[i*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (granted channel only)
//   out_data  : registered data of the selected beat
//   out_sel   : registered index of the channel that supplied out_data
//   out_valid : output register holds a beat
//   out_ready : downstream accepts the output beat
// -----------------------------------------------------------------------------
module muxn_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;

  logic [SW-1:0] w_ptr;
  logic          w_load_en;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_grant_idx;
  logic          w_found;
  logic [W-1:0]  w_grant_data;
  logic          w_xfer;
  logic [SW-1:0] w_next_ptr;

  // The output register may take a new beat when it is empty or is being
  // drained on this same edge.
  assign w_load_en = !r_out_valid | out_ready;

  // Two-pass search. The first pass covers channels at or above the pointer.
  // The second pass covers the wrapped part below it, and it can only match
  // when the first pass found nothing. With the pointer at 0 the second pass
  // never matches, which gives fixed lowest-index priority.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && in_valid[i] && (SW'(i) >= w_ptr)) begin
        w_found     = 1'b1;
        w_grant[i]  = 1'b1;
        w_grant_idx = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && in_valid[i]) begin
        w_found     = 1'b1;
        w_grant[i]  = 1'b1;
        w_grant_idx = SW'(i);
      end
    end
  end

  // Data of the granted channel. Other channels' data is ignored, so it may be
  // unstable while their valid is low.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_grant_data = in_data[i*W +: W];
    end
  end

  // rst_n gates ready so no channel sees a handshake while reset is held.
  assign in_ready = w_grant & {N{w_load_en & rst_n}};
  assign w_xfer   = |(in_valid & in_ready);

  assign w_next_ptr = (w_grant_idx == LAST_IDX) ? '0 : (w_grant_idx + SW'(1));

`ifdef MUXN_RR_ROUND_ROBIN_EN
  logic [SW-1:0] r_ptr;

  // The pointer moves only when a beat transfers, so idle cycles keep the
  // fairness order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_next_ptr;
    end
  end

  assign w_ptr = r_ptr;
`else
  // Fixed priority: no pointer state. The search always starts at channel 0.
  assign w_ptr = '0;
  logic w_unused_ptr;
  assign w_unused_ptr = ^w_next_ptr;
`endif

  // Output stage. A transfer loads a new beat, which covers the drain-and-load
  // case. A drain with no transfer empties the stage. Otherwise the stage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_grant_data;
      r_out_sel   <= w_grant_idx;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_muxn_rr.sv
// -----------------------------------------------------------------------------
// tb_muxn_rr -- directed bench for muxn_rr with N=4, W=8, SW=2.
//
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// The bench keeps its own arbitration model: a priority pointer, plus a queue
// of beats expected in the output register. A beat is pushed when the model
// predicts a transfer and popped when the output handshake completes.
// The model follows MUXN_RR_ROUND_ROBIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_muxn_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  // Each entry holds {sel, data} for a beat that should be in the output register.
  logic [SW+W-1:0] exp_q[$];
  int              m_ptr;
  int              checks = 0;
  int              errors = 0;

  muxn_rr #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model arbitration: scan from the pointer, wrapping modulo N.
  function automatic int m_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check in_ready and the output stage against
  // the model, then advance the model across the next rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    logic          exp_valid;
    logic          load;
    logic [N-1:0]  exp_rdy;
    logic [SW+W-1:0] item;
    int            g;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_valid = (exp_q.size() != 0);
    check("out_valid", out_valid, exp_valid);
    load    = !exp_valid || ordy;
    g       = m_grant(v);
    exp_rdy = (g >= 0 && load) ? (N'(1) << g) : '0;
    check("in_ready", in_ready, exp_rdy);
    if (exp_valid && !ordy) begin
      check("held_data", out_data, exp_q[0][W-1:0]);
      check("held_sel", out_sel, exp_q[0][SW+W-1:W]);
    end
    if (exp_valid && ordy) begin
      item = exp_q.pop_front();
      check("out_data", out_data, item[W-1:0]);
      check("out_sel", out_sel, item[SW+W-1:W]);
    end
    if (g >= 0 && load) begin
      exp_q.push_back({SW'(g), d[g*W +: W]});
`ifdef MUXN_RR_ROUND_ROBIN_EN
      m_ptr = (g + 1) % N;
`endif
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [N*W-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h1122_3344;
    out_ready = 1'b1;
    m_ptr     = 0;
    #12;
    // Reset state, with every channel requesting.
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_sel", out_sel, 2'd0);
    check("rst_in_ready", in_ready, 4'b0000);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;

    // All channels valid, output always ready: one beat per cycle, rotating order.
    for (int i = 0; i < 6; i++) step(4'hF, rnd_data(), 1'b1);

    // Only ch2 valid, carrying 0xA5.
    d = rnd_data();
    d[2*W +: W] = 8'hA5;
    step(4'b0100, d, 1'b1);
    step(4'b0000, rnd_data(), 1'b1);

    // Beat 0x3C from ch1, held for 3 cycles of backpressure.
    d = rnd_data();
    d[1*W +: W] = 8'h3C;
    step(4'b0010, d, 1'b1);
    for (int i = 0; i < 3; i++) step(4'hF, rnd_data(), 1'b0);
    step(4'hF, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b1);

    // ch3 granted last, then ch0 and ch3 both valid: the search wraps to ch0.
    step(4'b1000, rnd_data(), 1'b1);
    step(4'b1001, rnd_data(), 1'b1);
    step(4'b1001, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b1);

    // Random valid and backpressure patterns.
    for (int i = 0; i < 40; i++)
      step(N'($urandom_range(0, 15)), rnd_data(), 1'($urandom_range(0, 1)));

    // Reset in the middle of a held beat.
    step(4'b0100, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b0);
    @(negedge clk);
    in_valid = 4'hF;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_out_sel", out_sel, 2'd0);
    check("midrst_in_ready", in_ready, 4'b0000);
    exp_q.delete();
    m_ptr = 0;
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;

    // The first grant after reset starts from ch0.
    step(4'b1010, rnd_data(), 1'b1);
    step(4'hF, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b1);
    step(4'b0000, rnd_data(), 1'b1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 SHALL provide parameter N, default 4: number of input channels, 2..16.
REQ-002 SHALL provide parameter W, default 8: data width per channel, 1..64.
REQ-003 SHALL provide parameter SW, default 2: select/index width; N <= 2**SW.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-007 SHALL have port in_valid  input  N  per-channel valid.
REQ-008 SHALL have port in_ready  output  N  per-channel ready.
REQ-009 SHALL have port out_data  output  W  registered selected data.
REQ-010 SHALL have port out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-011 SHALL have port out_valid  output  1  output register holds a beat.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-013 SHALL define load_en = !out_valid | out_ready; a new beat loads only when load_en = 1.
REQ-014 SHALL grant at most one channel per cycle, combinationally from in_valid and the priority pointer ptr.
REQ-015 SHALL drive in_ready[i] = grant[i] & load_en; in_ready is 0 for all non-granted channels.
REQ-016 SHALL transfer channel i when in_valid[i] & in_ready[i]; on the next edge out_data = channel i data, out_sel = i, out_valid = 1 (latency 1 cycle).
REQ-017 SHALL clear out_valid on an edge where out_valid & out_ready and no input transfers.
REQ-018 SHALL, on simultaneous drain and transfer, load the new beat with out_valid staying 1 (full throughput, one beat/cycle).
REQ-019 SHALL hold out_data, out_sel, out_valid stable while out_valid & !out_ready.
REQ-020 SHALL, when no in_valid is set, grant nothing and leave ptr unchanged.
REQ-021 SHALL, after a transfer from channel i, set ptr = (i+1) mod N; wrap from N-1 to 0.
REQ-022 SHALL search from ptr upward, wrapping modulo N, and grant the first channel with in_valid set.
REQ-023 SHALL ignore in_data of non-granted channels; in_data is not required to be stable when in_valid = 0.

Reset
REQ-024 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, independent of clk.
REQ-025 SHALL drive in_ready = 0 on all channels while rst_n = 0.
REQ-026 SHALL discard any held beat on reset mid-operation; first transfer after release grants from channel 0 upward.

Configuration
REQ-027 SHALL honour macro MUXN_RR_ROUND_ROBIN_EN: defined -> round-robin per REQ-021/REQ-022.
REQ-028 SHALL, with MUXN_RR_ROUND_ROBIN_EN undefined, use fixed priority (lowest index wins), ptr removed and held at 0; all other behaviour unchanged.

Verification (N=4, W=8, macro defined unless noted)
REQ-029 SHALL cover: rst_n=0 mid-beat with out_valid=1 -> out_valid=0, out_data=0x00, out_sel=0 immediately, without waiting for an edge.
REQ-030 SHALL cover: only ch2 valid with 0xA5, out_ready=1 -> next cycle out_data=0xA5, out_sel=2, out_valid=1.
REQ-031 SHALL cover: all 4 valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with beat 0x3C held -> out_data stays 0x3C, in_ready=0000; beat advances on the cycle after out_ready=1.
REQ-033 SHALL cover: ch3 last granted, ch0 and ch3 valid -> ch0 granted (wrap-around).
REQ-034 SHALL cover: macro undefined, all 4 valid, out_ready=1 -> out_sel=0 every cycle.
